aes_block_packer: RTL and testbench

//  Upstream feeder for the combinational AES-128 encrypt core: packs an 8-bit byte stream (valid/ready)

---
 rtl/aes_block_packer_pkg.sv | 25 ++
 rtl/aes_pad_fill.sv | 39 +++
 rtl/aes_block_packer.sv | 188 ++++++++++++++++++
 tb/tb_aes_block_packer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/aes_block_packer_pkg.sv
// ---------------------------------------------------------------------------
// aes_block_packer_pkg
//   Shared definitions for the AES plaintext block packer: block geometry,
//   byte-counter width, FSM state encodings and the PKCS#7 fill helper.
//   Optional feature macro used by the importing files: AES_BLOCK_PACKER_PAD_EN.
// ---------------------------------------------------------------------------
package aes_block_packer_pkg;

  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES_BLOCK_W     = AES_BLOCK_BYTES * 8;
  localparam int AES_CNT_W       = 5;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_HOLD = 2'd1,
    ST_PAD  = 2'd2
  } state_t;

  // PKCS#7: every fill byte carries the number of missing bytes.
  function automatic logic [7:0] pkcs7_value(input logic [AES_CNT_W-1:0] n,
                                             input int block_bytes);
    return 8'(block_bytes) - {3'b000, n};
  endfunction

endpackage

// File: rtl/aes_pad_fill.sv
// ---------------------------------------------------------------------------
// aes_pad_fill
//   Combinational tail filler: keeps the first i_count bytes of the raw block
//   (byte 0 in the top byte lane) and replaces every later byte with the fill
//   value. The fill value is FILL_BYTE by default, or the PKCS#7 value
//   (block_bytes - i_count) when AES_BLOCK_PACKER_PAD_EN is defined.
// Ports
//   i_raw    in  BLOCK_BYTES*8  raw block, unused slots don't care
//   i_count  in  5              number of valid message bytes (1..BLOCK_BYTES)
//   o_block  out BLOCK_BYTES*8  filled block, no undefined bits
// ---------------------------------------------------------------------------
module aes_pad_fill
  import aes_block_packer_pkg::*;
#(
  parameter int          BLOCK_BYTES = AES_BLOCK_BYTES,
  parameter logic [7:0]  FILL_BYTE   = 8'h00
) (
  input  logic [BLOCK_BYTES*8-1:0] i_raw,
  input  logic [AES_CNT_W-1:0]     i_count,
  output logic [BLOCK_BYTES*8-1:0] o_block
);

  logic [7:0] w_fill;

`ifdef AES_BLOCK_PACKER_PAD_EN
  assign w_fill = pkcs7_value(i_count, BLOCK_BYTES);
`else
  assign w_fill = FILL_BYTE;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < BLOCK_BYTES; gi++) begin : g_byte
      localparam int LSB = (BLOCK_BYTES - 1 - gi) * 8;
      assign o_block[LSB +: 8] = (AES_CNT_W'(gi) < i_count) ? i_raw[LSB +: 8] : w_fill;
    end
  endgenerate

endmodule

// File: rtl/aes_block_packer.sv
// ---------------------------------------------------------------------------
// aes_block_packer
//   Packs an 8-bit valid/ready byte stream into AES plaintext blocks and
//   presents each block with valid/ready. Byte 0 of a block is placed in
//   out_block[127:120]. Fill and hold never overlap: in_ready is high only in
//   FILL, out_valid only in HOLD/PAD.
//   Optional macro AES_BLOCK_PACKER_PAD_EN: PKCS#7 padding, including an extra
//   all-8'h10 block after a message that ends on a block boundary. Without it
//   the tail is filled with FILL_BYTE and a full final block carries out_last.
// Ports
//   clk, rst    clock (rising edge), asynchronous active-high reset
//   in_byte     in  8    message byte
//   in_valid    in  1    in_byte valid
//   in_last     in  1    in_byte is the final message byte
//   in_ready    out 1    byte accepted this cycle when in_valid is high
//   out_block   out 128  packed block
//   out_valid   out 1    out_block valid
//   out_last    out 1    final block of the message
//   out_nbytes  out 5    message bytes in block (0 for a pure pad block)
//   out_ready   in  1    consumer takes the block
// ---------------------------------------------------------------------------
module aes_block_packer
  import aes_block_packer_pkg::*;
#(
  parameter int          BLOCK_BYTES = AES_BLOCK_BYTES,
  parameter logic [7:0]  FILL_BYTE   = 8'h00
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               in_byte,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [BLOCK_BYTES*8-1:0] out_block,
  output logic                     out_valid,
  output logic                     out_last,
  output logic [AES_CNT_W-1:0]     out_nbytes,
  input  logic                     out_ready
);

  localparam int                   BW        = BLOCK_BYTES * 8;
  localparam logic [AES_CNT_W-1:0] LAST_SLOT = AES_CNT_W'(BLOCK_BYTES - 1);
`ifdef AES_BLOCK_PACKER_PAD_EN
  localparam logic [AES_CNT_W-1:0] FULL_CNT  = AES_CNT_W'(BLOCK_BYTES);
  localparam logic [7:0]           PAD_FULL  = 8'(BLOCK_BYTES);
`endif

  state_t               r_state, w_state_next;
  logic [AES_CNT_W-1:0] r_cnt, w_cnt_next;
  logic [BW-1:0]        r_raw, w_raw_next;
  logic [BW-1:0]        r_block, w_block_next;
  logic [AES_CNT_W-1:0] r_nbytes, w_nbytes_next;
  logic                 r_last, w_last_next;
`ifdef AES_BLOCK_PACKER_PAD_EN
  logic                 r_pad_pending, w_pad_pending_next;
`endif

  logic [BW-1:0]        w_raw_ins;
  logic [BW-1:0]        w_filled;
  logic [AES_CNT_W-1:0] w_fill_count;

  // Raw block with the incoming byte dropped into slot r_cnt.
  genvar gi;
  generate
    for (gi = 0; gi < BLOCK_BYTES; gi++) begin : g_slot
      localparam int LSB = (BLOCK_BYTES - 1 - gi) * 8;
      assign w_raw_ins[LSB +: 8] = (r_cnt == AES_CNT_W'(gi)) ? in_byte : r_raw[LSB +: 8];
    end
  endgenerate

  assign w_fill_count = r_cnt + 5'd1;

  aes_pad_fill #(
    .BLOCK_BYTES (BLOCK_BYTES),
    .FILL_BYTE   (FILL_BYTE)
  ) u_pad_fill (
    .i_raw   (w_raw_ins),
    .i_count (w_fill_count),
    .o_block (w_filled)
  );

  assign in_ready   = (r_state == ST_FILL);
  assign out_valid  = (r_state != ST_FILL);
  assign out_block  = r_block;
  assign out_last   = r_last;
  assign out_nbytes = r_nbytes;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_FILL;
      r_cnt         <= '0;
      r_raw         <= '0;
      r_block       <= '0;
      r_nbytes      <= '0;
      r_last        <= 1'b0;
`ifdef AES_BLOCK_PACKER_PAD_EN
      r_pad_pending <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_raw         <= w_raw_next;
      r_block       <= w_block_next;
      r_nbytes      <= w_nbytes_next;
      r_last        <= w_last_next;
`ifdef AES_BLOCK_PACKER_PAD_EN
      r_pad_pending <= w_pad_pending_next;
`endif
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = r_cnt;
    w_raw_next         = r_raw;
    w_block_next       = r_block;
    w_nbytes_next      = r_nbytes;
    w_last_next        = r_last;
`ifdef AES_BLOCK_PACKER_PAD_EN
    w_pad_pending_next = r_pad_pending;
`endif
    case (r_state)
      ST_FILL: begin
        if (in_valid) begin
          if (in_last || (r_cnt == LAST_SLOT)) begin
            // Block complete: latch the filled image and start clean.
            w_state_next  = ST_HOLD;
            w_block_next  = w_filled;
            w_nbytes_next = w_fill_count;
            w_cnt_next    = '0;
            w_raw_next    = '0;
`ifdef AES_BLOCK_PACKER_PAD_EN
            // A message ending on a block boundary still owes a pad block.
            if (in_last && (w_fill_count == FULL_CNT)) begin
              w_last_next        = 1'b0;
              w_pad_pending_next = 1'b1;
            end else begin
              w_last_next = in_last;
            end
`else
            w_last_next   = in_last;
`endif
          end else begin
            w_cnt_next = w_fill_count;
            w_raw_next = w_raw_ins;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          w_state_next  = ST_FILL;
          w_block_next  = '0;
          w_nbytes_next = '0;
          w_last_next   = 1'b0;
          w_cnt_next    = '0;
`ifdef AES_BLOCK_PACKER_PAD_EN
          if (r_pad_pending) begin
            w_state_next       = ST_PAD;
            w_block_next       = {BLOCK_BYTES{PAD_FULL}};
            w_last_next        = 1'b1;
            w_pad_pending_next = 1'b0;
          end
`endif
        end
      end
`ifdef AES_BLOCK_PACKER_PAD_EN
      ST_PAD: begin
        if (out_ready) begin
          w_state_next  = ST_FILL;
          w_block_next  = '0;
          w_nbytes_next = '0;
          w_last_next   = 1'b0;
          w_cnt_next    = '0;
        end
      end
`endif
      default: begin
        w_state_next  = ST_FILL;
        w_block_next  = '0;
        w_nbytes_next = '0;
        w_last_next   = 1'b0;
        w_cnt_next    = '0;
        w_raw_next    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_block_packer.sv
// ---------------------------------------------------------------------------
// tb_aes_block_packer
//   Directed bench for aes_block_packer. Expectations depend on whether
//   AES_BLOCK_PACKER_PAD_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_aes_block_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_byte;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [127:0] out_block;
  logic         out_valid;
  logic         out_last;
  logic [4:0]   out_nbytes;
  logic         out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  aes_block_packer dut (
    .clk        (clk),
    .rst        (rst),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_block  (out_block),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_nbytes (out_nbytes),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    in_byte  = b;
    in_valid = 1'b1;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Checks the presented block, then takes it with a one-cycle out_ready.
  task automatic take_block(input string tag, input logic [127:0] exp_blk,
                            input logic [4:0] exp_n, input logic exp_last);
    check_eq({tag, "_valid"}, out_valid, 1'b1);
    check_eq({tag, "_block"}, out_block, exp_blk);
    check_eq({tag, "_nbytes"}, out_nbytes, exp_n);
    check_eq({tag, "_last"}, out_last, exp_last);
    $display("block %s: %h nbytes=%0d last=%0b", tag, out_block, out_nbytes, out_last);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [127:0] exp_blk;
  logic [7:0]   fill3;
  logic [7:0]   fill1;

  initial begin
    rst = 1'b1; in_byte = 8'h00; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
`ifdef AES_BLOCK_PACKER_PAD_EN
    fill3 = 8'h0D;
    fill1 = 8'h0F;
`else
    fill3 = 8'h00;
    fill1 = 8'h00;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_block", out_block, 128'h0);
    check_eq("rst_last", out_last, 1'b0);
    check_eq("rst_nbytes", out_nbytes, 5'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_in_ready", in_ready, 1'b1);

    // 1: sixteen bytes, valid appears right after the 16th accepting edge.
    for (int i = 0; i < 15; i++) send_byte(8'(i), 1'b0);
    check_eq("t1_valid_early", out_valid, 1'b0);
    check_eq("t1_ready_early", in_ready, 1'b1);
    send_byte(8'h0F, 1'b0);
    check_eq("t1_in_ready", in_ready, 1'b0);
    take_block("t1", 128'h000102030405060708090A0B0C0D0E0F, 5'd16, 1'b0);
    check_eq("t1_after_valid", out_valid, 1'b0);
    check_eq("t1_after_block", out_block, 128'h0);
    check_eq("t1_after_ready", in_ready, 1'b1);

    // 5: stall in HOLD while upstream keeps offering bytes.
    for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 1'b0);
    in_byte = 8'hEE; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_eq("t5_in_ready", in_ready, 1'b0);
      check_eq("t5_block", out_block, 128'h101112131415161718191A1B1C1D1E1F);
    end
    in_valid = 1'b0;
    take_block("t5", 128'h101112131415161718191A1B1C1D1E1F, 5'd16, 1'b0);

    // 2 / 4a: short final block.
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    exp_blk = {8'hAA, 8'hBB, 8'hCC, {13{fill3}}};
    take_block("t2", exp_blk, 5'd3, 1'b1);

    // 3 / 4b: final block exactly full.
    for (int i = 0; i < 15; i++) send_byte(8'(8'h30 + i), 1'b0);
    send_byte(8'h3F, 1'b1);
`ifdef AES_BLOCK_PACKER_PAD_EN
    take_block("t3_data", 128'h303132333435363738393A3B3C3D3E3F, 5'd16, 1'b0);
    take_block("t3_pad", {16{8'h10}}, 5'd0, 1'b1);
`else
    take_block("t3_data", 128'h303132333435363738393A3B3C3D3E3F, 5'd16, 1'b1);
`endif
    check_eq("t3_done_valid", out_valid, 1'b0);

    // Last on the very first byte.
    send_byte(8'h5A, 1'b1);
    exp_blk = {8'h5A, {15{fill1}}};
    take_block("t_one", exp_blk, 5'd1, 1'b1);

    // 6: reset after seven bytes drops the partial block.
    for (int i = 0; i < 7; i++) send_byte(8'(8'h70 + i), 1'b0);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_valid", out_valid, 1'b0);
    check_eq("t6_rst_block", out_block, 128'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("t6_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 15; i++) send_byte(8'(8'h40 + i), 1'b0);
    check_eq("t6_valid_early", out_valid, 1'b0);
    send_byte(8'h4F, 1'b0);
    take_block("t6", 128'h404142434445464748494A4B4C4D4E4F, 5'd16, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
